fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the fetch stage: drives PC write-enable, PC next-source select and
//  IF/ID write/flush. Sequences boot from the reset vector, load-use stalls and
//  branch redirects from EX/MEM, inserting PIPE_BUBBLES flush cycles after each redirect.
//  Sits beside the fetch stage; consumes hazard-unit stall and EX/MEM redirect requests.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded in BOOT
//  PIPE_BUBBLES  2              IF/ID flush cycles per redirect (legal 1..7), REDIRECT included
//  CNT_W         16             width of redirect_count
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous, active-high reset
//  stall_req       in   1      hazard unit requests fetch freeze (load-use)
//  PC_Src          in   1      EX/MEM requests redirect to EX_MEM_NPC
//  EX_MEM_NPC      in   32     redirect target, valid when PC_Src=1
//  pc_we           out  1      PC register load enable
//  pc_sel          out  2      next-PC mux: 00 incrementer, 01 pc_target, 10 reset_pc
//  pc_target       out  32     registered redirect target
//  reset_pc        out  32     constant RESET_PC
//  if_id_we        out  1      IF/ID register load enable
//  if_id_flush     out  1      IF/ID loads a NOP (32'h0) instead of fetched word
//  redirect_count  out  CNT_W  number of accepted redirects, wraps
// BEHAVIOUR
//  - Reset (rst=1 at edge): state<=BOOT, pc_target<=0, bub_cnt<=0, redirect_count<=0.
//    While rst=1 outputs forced: pc_we=0, if_id_we=0, if_id_flush=1, pc_sel=00.
//  - States: BOOT, FETCH, REDIRECT, FLUSH.
//  - BOOT (1 cycle): pc_sel=10, pc_we=1, if_id_flush=1, if_id_we=1 -> FETCH.
//    PC_Src/stall_req ignored in BOOT.
//  - FETCH: pc_sel=00; pc_we=if_id_we=~stall_req (Mealy, same cycle); if_id_flush=0.
//  - Redirect accept: PC_Src=1 in FETCH or FLUSH (stall_req irrelevant): at edge
//    pc_target<=EX_MEM_NPC, redirect_count<=redirect_count+1, state<=REDIRECT.
//    In the accept cycle itself outputs remain the current state's (FETCH or FLUSH).
//  - REDIRECT (1 cycle): pc_sel=01, pc_we=1, if_id_we=1, if_id_flush=1;
//    bub_cnt<=PIPE_BUBBLES-1; ->FLUSH if PIPE_BUBBLES>1 else ->FETCH.
//    PC_Src in REDIRECT ignored (target already selected; EX/MEM holds a flushed slot).
//  - FLUSH: pc_sel=00, pc_we=1, if_id_we=1, if_id_flush=1, bub_cnt decrements;
//    ->FETCH when bub_cnt==1. stall_req ignored (flush wins over stall).
//    PC_Src in FLUSH: newer redirect, re-accept as above (bub_cnt reloaded in REDIRECT).
//  - Priority: rst > BOOT > PC_Src > stall_req > normal fetch.
//  - Latency: PC_Src at cycle t -> pc_sel=01/pc_we=1 at t+1 -> PC=target after t+1
//    edge; IF/ID flushed at t+1..t+PIPE_BUBBLES; first real IF/ID load at t+PIPE_BUBBLES+1.
//  - redirect_count wraps 2^CNT_W-1 -> 0, no saturation.
//  - rst mid-REDIRECT/FLUSH: abandons pending target; resumes via BOOT.
//  - Illegal state encodings decode to BOOT.
// STRUCTURE
//  - Shared package/header: state encodings (BOOT=2'd0,FETCH=2'd1,REDIRECT=2'd2,
//    FLUSH=2'd3), pc_sel codes (PCSEL_INC/PCSEL_TGT/PCSEL_RST), NOP word 32'h0.
//  - Single flat module: state reg, bub_cnt (3b), pc_target reg, redirect counter,
//    combinational output decode. No sub-modules.
//  - Integrates with the fetch stage by widening the next-PC mux to 3 inputs and adding
//    we/flush to PC and IF/ID.
// TESTING
//  1. rst 3 cycles, release -> 1 cycle BOOT: pc_sel=10,pc_we=1,if_id_flush=1; then FETCH
//     pc_sel=00,pc_we=1,if_id_flush=0; redirect_count=0.
//  2. FETCH, stall_req=1 for 3 cycles -> pc_we=if_id_we=0 exactly those 3 cycles,
//     state stays FETCH, pc_sel=00.
//  3. FETCH, PC_Src=1,EX_MEM_NPC=32'h0000_0040 one cycle -> next cycle pc_sel=01,
//     pc_target=32'h40, flush=1; flush=1 for 2 cycles total; redirect_count=1.
//  4. stall_req=1 and PC_Src=1 same cycle (target 32'h80) -> redirect accepted,
//     REDIRECT next cycle with pc_we=1 despite stall_req held high.
//  5. PC_Src in 2nd FLUSH-adjacent cycle with new target 32'hC0 -> second REDIRECT,
//     pc_target=32'hC0, flush window restarts, redirect_count=2.
//  6. rst asserted during REDIRECT -> next cycle pc_we=0,flush=1, count=0, BOOT after
//     release; redirect_count wrap check with CNT_W=2: 4 redirects -> 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer.
//   state_t     : sequencer states (BOOT, FETCH, REDIRECT, FLUSH)
//   PCSEL_*     : next-PC mux select codes
//   NOP_WORD    : instruction word loaded into IF/ID on a flush
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      FETCH    = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   localparam logic [1:0]  PCSEL_INC = 2'b00;  // sequential PC + 4
   localparam logic [1:0]  PCSEL_TGT = 2'b01;  // registered redirect target
   localparam logic [1:0]  PCSEL_RST = 2'b10;  // reset vector

   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boots the PC from the reset vector, freezes fetch on
// load-use stalls and redirects the PC on EX/MEM branch resolution, flushing
// IF/ID for PIPE_BUBBLES cycles (REDIRECT cycle included) after each redirect.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall_req       : hazard unit freeze request
//   PC_Src          : EX/MEM redirect request, target on EX_MEM_NPC
//   pc_we, pc_sel   : PC load enable and next-PC mux select
//   pc_target       : registered redirect target (mux input 01)
//   reset_pc        : constant reset vector (mux input 10)
//   if_id_we        : IF/ID load enable
//   if_id_flush     : IF/ID loads NOP instead of the fetched word
//   redirect_count  : accepted redirects, wrapping
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          PIPE_BUBBLES = 2,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             PC_Src,
   input  logic [31:0]      EX_MEM_NPC,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [31:0]      pc_target,
   output logic [31:0]      reset_pc,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic [CNT_W-1:0] redirect_count
);

   state_t     state, state_nxt;
   logic [2:0] bub_cnt;
   logic       accept;

   assign reset_pc = RESET_PC;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= BOOT;
         pc_target      <= '0;
         bub_cnt        <= '0;
         redirect_count <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pc_target      <= EX_MEM_NPC;
            redirect_count <= redirect_count + 1'b1;
         end
         // Reload happens in REDIRECT so a re-accept from FLUSH restarts the window.
         if (state == REDIRECT)
            bub_cnt <= 3'(PIPE_BUBBLES - 1);
         else if (state == FLUSH)
            bub_cnt <= bub_cnt - 3'd1;
      end
   end

   always_comb begin
      state_nxt   = BOOT;
      accept      = 1'b0;
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      pc_sel      = PCSEL_INC;
      case (state)
         BOOT: begin
            pc_sel      = PCSEL_RST;
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            state_nxt   = FETCH;
         end
         FETCH: begin
            pc_we       = ~stall_req;
            if_id_we    = ~stall_req;
            if_id_flush = 1'b0;
            accept      = PC_Src;
            state_nxt   = PC_Src ? REDIRECT : FETCH;
         end
         REDIRECT: begin
            pc_sel      = PCSEL_TGT;
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            state_nxt   = (PIPE_BUBBLES > 1) ? FLUSH : FETCH;
         end
         FLUSH: begin
            // Flush wins over stall: the slot is discarded anyway.
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            accept      = PC_Src;
            if (PC_Src)
               state_nxt = REDIRECT;
            else if (bub_cnt == 3'd1)
               state_nxt = FETCH;
            else
               state_nxt = FLUSH;
         end
         default: state_nxt = BOOT;
      endcase
      if (rst) begin
         accept      = 1'b0;
         pc_we       = 1'b0;
         if_id_we    = 1'b0;
         if_id_flush = 1'b1;
         pc_sel      = PCSEL_INC;
      end
   end

endmodule
